// File: rtl/cpu_pkg.sv
// Shared CPU definitions: datapath widths, ALU opcodes, forward-select encoding
// and the ID/EX payload carried between the decode and execute stages.
package cpu_pkg;

    localparam int unsigned DATA_W  = 32;
    localparam int unsigned REG_W   = 5;
    localparam int unsigned ALUOP_W = 6;
    localparam int unsigned SHAMT_W = 5;

    localparam logic [ALUOP_W-1:0] ALU_SLL = 6'b000000;
    localparam logic [ALUOP_W-1:0] ALU_SRL = 6'b000010;
    localparam logic [ALUOP_W-1:0] ALU_ADD = 6'b100000;
    localparam logic [ALUOP_W-1:0] ALU_SUB = 6'b100010;
    localparam logic [ALUOP_W-1:0] ALU_AND = 6'b100100;
    localparam logic [ALUOP_W-1:0] ALU_OR  = 6'b100101;
    localparam logic [ALUOP_W-1:0] ALU_SLT = 6'b101010;

    typedef enum logic [1:0] {
        FWD_RF  = 2'd0,
        FWD_MEM = 2'd1,
        FWD_WB  = 2'd2
    } fwd_sel_e;

    typedef struct packed {
        logic               valid;
        logic               reg_write;
        logic               mem_read;
        logic               mem_write;
        logic               mem_to_reg;
        logic               alu_src;
        logic               shift_src;
        logic [ALUOP_W-1:0] alu_control;
        logic [REG_W-1:0]   rs;
        logic [REG_W-1:0]   rt;
        logic [REG_W-1:0]   write_reg;
        logic [SHAMT_W-1:0] shamt;
        logic [DATA_W-1:0]  read_data1;
        logic [DATA_W-1:0]  read_data2;
        logic [DATA_W-1:0]  sign_ext_imm;
    } id_ex_t;

    // A later stage writing a nonzero register that matches idx supplies its value.
    function automatic logic fwd_hit(input logic reg_write,
                                     input logic [REG_W-1:0] write_reg,
                                     input logic [REG_W-1:0] idx);
        return reg_write && (write_reg == idx) && (idx != '0);
    endfunction

endpackage

// File: rtl/fwd_mux.sv
// Operand forwarding mux: picks EX/MEM, then MEM/WB, then the register-file value.
module fwd_mux
    import cpu_pkg::*;
(
    input  logic [REG_W-1:0]  idx,
    input  logic [DATA_W-1:0] rf_data,
    input  logic              mem_reg_write,
    input  logic [REG_W-1:0]  mem_write_reg,
    input  logic [DATA_W-1:0] mem_data,
    input  logic              wb_reg_write,
    input  logic [REG_W-1:0]  wb_write_reg,
    input  logic [DATA_W-1:0] wb_data,
    output logic [DATA_W-1:0] data,
    output fwd_sel_e          sel
);

    // The youngest producer (MEM) wins over the older one (WB).
    always_comb begin
        sel  = FWD_RF;
        data = rf_data;
        if (fwd_hit(mem_reg_write, mem_write_reg, idx)) begin
            sel  = FWD_MEM;
            data = mem_data;
        end else if (fwd_hit(wb_reg_write, wb_write_reg, idx)) begin
            sel  = FWD_WB;
            data = wb_data;
        end
    end

endmodule

// File: rtl/id_ex_stage.sv
// ID/EX pipeline register with ALU operand selection, optional forwarding and
// load-use bubble insertion. Build option: ID_EX_FORWARD_EN enables forwarding
// and hazard detection; without it operands come straight from the register.
module id_ex_stage
    import cpu_pkg::*;
(
    input  logic               Clk,
    input  logic               Rst,
    input  logic               Stall,
    input  logic               Flush,
    input  logic               ID_Valid,
    input  logic [DATA_W-1:0]  ID_ReadData1,
    input  logic [DATA_W-1:0]  ID_ReadData2,
    input  logic [DATA_W-1:0]  ID_SignExtImm,
    input  logic [SHAMT_W-1:0] ID_Shamt,
    input  logic [REG_W-1:0]   ID_Rs,
    input  logic [REG_W-1:0]   ID_Rt,
    input  logic [REG_W-1:0]   ID_Rd,
    input  logic [ALUOP_W-1:0] ID_ALUControl,
    input  logic               ID_ALUSrc,
    input  logic               ID_ShiftSrc,
    input  logic               ID_RegDst,
    input  logic               ID_RegWrite,
    input  logic               ID_MemRead,
    input  logic               ID_MemWrite,
    input  logic               ID_MemToReg,
    input  logic               MEM_RegWrite,
    input  logic [REG_W-1:0]   MEM_WriteReg,
    input  logic [DATA_W-1:0]  MEM_ALUResult,
    input  logic               WB_RegWrite,
    input  logic [REG_W-1:0]   WB_WriteReg,
    input  logic [DATA_W-1:0]  WB_WriteData,
    output logic [DATA_W-1:0]  EX_A,
    output logic [DATA_W-1:0]  EX_B,
    output logic [ALUOP_W-1:0] EX_ALUControl,
    output logic [DATA_W-1:0]  EX_StoreData,
    output logic [REG_W-1:0]   EX_WriteReg,
    output logic               EX_Valid,
    output logic               EX_RegWrite,
    output logic               EX_MemRead,
    output logic               EX_MemWrite,
    output logic               EX_MemToReg,
    output logic               LoadUseStall
);

    id_ex_t            id_d;
    id_ex_t            ex_q;
    logic [DATA_W-1:0] fwd_rs;
    logic [DATA_W-1:0] fwd_rt;

    // Pack the decoded instruction; destination is resolved here.
    always_comb begin
        id_d              = '0;
        id_d.valid        = ID_Valid;
        id_d.reg_write    = ID_RegWrite;
        id_d.mem_read     = ID_MemRead;
        id_d.mem_write    = ID_MemWrite;
        id_d.mem_to_reg   = ID_MemToReg;
        id_d.alu_src      = ID_ALUSrc;
        id_d.shift_src    = ID_ShiftSrc;
        id_d.alu_control  = ID_ALUControl;
        id_d.rs           = ID_Rs;
        id_d.rt           = ID_Rt;
        id_d.write_reg    = ID_RegDst ? ID_Rd : ID_Rt;
        id_d.shamt        = ID_Shamt;
        id_d.read_data1   = ID_ReadData1;
        id_d.read_data2   = ID_ReadData2;
        id_d.sign_ext_imm = ID_SignExtImm;
    end

    // Stage register: reset > flush/load-use bubble > hold > load.
    always_ff @(posedge Clk) begin
        if (Rst) begin
            ex_q <= '0;
        end else if (Flush || LoadUseStall) begin
            ex_q <= '0;
        end else if (!Stall) begin
            ex_q <= id_d;
        end
    end

`ifdef ID_EX_FORWARD_EN
    fwd_sel_e sel_rs;
    fwd_sel_e sel_rt;
    logic     unused_sel;

    fwd_mux u_fwd_rs (
        .idx           (ex_q.rs),
        .rf_data       (ex_q.read_data1),
        .mem_reg_write (MEM_RegWrite),
        .mem_write_reg (MEM_WriteReg),
        .mem_data      (MEM_ALUResult),
        .wb_reg_write  (WB_RegWrite),
        .wb_write_reg  (WB_WriteReg),
        .wb_data       (WB_WriteData),
        .data          (fwd_rs),
        .sel           (sel_rs)
    );

    fwd_mux u_fwd_rt (
        .idx           (ex_q.rt),
        .rf_data       (ex_q.read_data2),
        .mem_reg_write (MEM_RegWrite),
        .mem_write_reg (MEM_WriteReg),
        .mem_data      (MEM_ALUResult),
        .wb_reg_write  (WB_RegWrite),
        .wb_write_reg  (WB_WriteReg),
        .wb_data       (WB_WriteData),
        .data          (fwd_rt),
        .sel           (sel_rt)
    );

    assign unused_sel = ^{sel_rs, sel_rt};

    // A load in EX cannot feed the next instruction in time; compare both sources conservatively.
    assign LoadUseStall = ex_q.valid && ex_q.mem_read && (ex_q.rt != '0) &&
                          ((ID_Rs == ex_q.rt) || (ID_Rt == ex_q.rt));
`else
    logic unused_fwd;

    assign fwd_rs       = ex_q.read_data1;
    assign fwd_rt       = ex_q.read_data2;
    assign LoadUseStall = 1'b0;
    assign unused_fwd   = ^{MEM_RegWrite, MEM_WriteReg, MEM_ALUResult,
                            WB_RegWrite, WB_WriteReg, WB_WriteData, ex_q.rs, ex_q.rt};
`endif

    // ALU operand steering; shifts take rt on A and the shift amount on B.
    always_comb begin
        EX_A = fwd_rs;
        EX_B = fwd_rt;
        if (ex_q.shift_src) begin
            EX_A = fwd_rt;
            EX_B = {DATA_W'(0)} | DATA_W'(ex_q.shamt);
        end else if (ex_q.alu_src) begin
            EX_B = ex_q.sign_ext_imm;
        end
    end

    assign EX_StoreData  = fwd_rt;
    assign EX_ALUControl = ex_q.alu_control;
    assign EX_WriteReg   = ex_q.write_reg;
    assign EX_Valid      = ex_q.valid;
    assign EX_RegWrite   = ex_q.reg_write;
    assign EX_MemRead    = ex_q.mem_read;
    assign EX_MemWrite   = ex_q.mem_write;
    assign EX_MemToReg   = ex_q.mem_to_reg;

endmodule

// File: tb/tb_id_ex_stage.sv
// Self-checking bench for id_ex_stage: directed scenarios plus a randomized run
// against a reference model of the stage. Honours ID_EX_FORWARD_EN like the RTL.
module tb_id_ex_stage;
    import cpu_pkg::*;

`ifdef ID_EX_FORWARD_EN
    localparam bit FWD = 1'b1;
`else
    localparam bit FWD = 1'b0;
`endif

    logic        Clk = 1'b0;
    logic        Rst, Stall, Flush, ID_Valid;
    logic [31:0] ID_ReadData1, ID_ReadData2, ID_SignExtImm;
    logic [4:0]  ID_Shamt, ID_Rs, ID_Rt, ID_Rd;
    logic [5:0]  ID_ALUControl;
    logic        ID_ALUSrc, ID_ShiftSrc, ID_RegDst, ID_RegWrite, ID_MemRead, ID_MemWrite, ID_MemToReg;
    logic        MEM_RegWrite, WB_RegWrite;
    logic [4:0]  MEM_WriteReg, WB_WriteReg;
    logic [31:0] MEM_ALUResult, WB_WriteData;
    logic [31:0] EX_A, EX_B, EX_StoreData;
    logic [5:0]  EX_ALUControl;
    logic [4:0]  EX_WriteReg;
    logic        EX_Valid, EX_RegWrite, EX_MemRead, EX_MemWrite, EX_MemToReg, LoadUseStall;

    always #5 Clk = ~Clk;

    id_ex_stage dut (
        .Clk(Clk), .Rst(Rst), .Stall(Stall), .Flush(Flush), .ID_Valid(ID_Valid),
        .ID_ReadData1(ID_ReadData1), .ID_ReadData2(ID_ReadData2), .ID_SignExtImm(ID_SignExtImm),
        .ID_Shamt(ID_Shamt), .ID_Rs(ID_Rs), .ID_Rt(ID_Rt), .ID_Rd(ID_Rd),
        .ID_ALUControl(ID_ALUControl), .ID_ALUSrc(ID_ALUSrc), .ID_ShiftSrc(ID_ShiftSrc),
        .ID_RegDst(ID_RegDst), .ID_RegWrite(ID_RegWrite), .ID_MemRead(ID_MemRead),
        .ID_MemWrite(ID_MemWrite), .ID_MemToReg(ID_MemToReg),
        .MEM_RegWrite(MEM_RegWrite), .MEM_WriteReg(MEM_WriteReg), .MEM_ALUResult(MEM_ALUResult),
        .WB_RegWrite(WB_RegWrite), .WB_WriteReg(WB_WriteReg), .WB_WriteData(WB_WriteData),
        .EX_A(EX_A), .EX_B(EX_B), .EX_ALUControl(EX_ALUControl), .EX_StoreData(EX_StoreData),
        .EX_WriteReg(EX_WriteReg), .EX_Valid(EX_Valid), .EX_RegWrite(EX_RegWrite),
        .EX_MemRead(EX_MemRead), .EX_MemWrite(EX_MemWrite), .EX_MemToReg(EX_MemToReg),
        .LoadUseStall(LoadUseStall)
    );

    // Instruction currently held in EX, as the model sees it.
    typedef struct {
        bit          valid, regwrite, memread, memwrite, memtoreg, alusrc, shiftsrc;
        bit [5:0]    aluc;
        bit [4:0]    rs, rt, wr, shamt;
        bit [31:0]   rd1, rd2, imm;
    } ex_model_t;

    ex_model_t   m;
    int unsigned total  = 0;
    int unsigned passed = 0;

    function automatic ex_model_t bubble();
        ex_model_t b;
        b.valid = 0; b.regwrite = 0; b.memread = 0; b.memwrite = 0; b.memtoreg = 0;
        b.alusrc = 0; b.shiftsrc = 0; b.aluc = 0; b.rs = 0; b.rt = 0; b.wr = 0;
        b.shamt = 0; b.rd1 = 0; b.rd2 = 0; b.imm = 0;
        return b;
    endfunction

    function automatic logic [31:0] fwd(input logic [4:0] r, input logic [31:0] rf);
        if (FWD && MEM_RegWrite && MEM_WriteReg == r && r != 0) return MEM_ALUResult;
        if (FWD && WB_RegWrite && WB_WriteReg == r && r != 0) return WB_WriteData;
        return rf;
    endfunction

    function automatic logic [31:0] exp_a();
        return m.shiftsrc ? fwd(m.rt, m.rd2) : fwd(m.rs, m.rd1);
    endfunction

    function automatic logic [31:0] exp_b();
        if (m.shiftsrc) return {27'b0, m.shamt};
        return m.alusrc ? m.imm : fwd(m.rt, m.rd2);
    endfunction

    function automatic logic exp_hz();
        return FWD && m.valid && m.memread && m.rt != 0 && (ID_Rs == m.rt || ID_Rt == m.rt);
    endfunction

    task automatic clear_id();
        ID_Valid = 0; ID_ReadData1 = 0; ID_ReadData2 = 0; ID_SignExtImm = 0; ID_Shamt = 0;
        ID_Rs = 0; ID_Rt = 0; ID_Rd = 0; ID_ALUControl = 0; ID_ALUSrc = 0; ID_ShiftSrc = 0;
        ID_RegDst = 0; ID_RegWrite = 0; ID_MemRead = 0; ID_MemWrite = 0; ID_MemToReg = 0;
    endtask

    task automatic clear_fwd();
        MEM_RegWrite = 0; MEM_WriteReg = 0; MEM_ALUResult = 0;
        WB_RegWrite = 0; WB_WriteReg = 0; WB_WriteData = 0;
    endtask

    // Advance the model with the inputs present at the edge, then the DUT.
    task automatic tick();
        bit hz;
        hz = exp_hz();
        if (Rst || Flush || hz) begin
            m = bubble();
        end else if (!Stall) begin
            m.valid = ID_Valid; m.regwrite = ID_RegWrite; m.memread = ID_MemRead;
            m.memwrite = ID_MemWrite; m.memtoreg = ID_MemToReg; m.alusrc = ID_ALUSrc;
            m.shiftsrc = ID_ShiftSrc; m.aluc = ID_ALUControl; m.rs = ID_Rs; m.rt = ID_Rt;
            m.wr = ID_RegDst ? ID_Rd : ID_Rt; m.shamt = ID_Shamt;
            m.rd1 = ID_ReadData1; m.rd2 = ID_ReadData2; m.imm = ID_SignExtImm;
        end
        @(posedge Clk);
        #1;
    endtask

    task automatic test_reset();
        Rst = 1; Stall = 0; Flush = 0;
        clear_id(); clear_fwd();
        ID_Valid = 1; ID_Rs = 1; ID_Rt = 2; ID_Rd = 3; ID_ReadData1 = 5; ID_ReadData2 = 3;
        ID_ALUControl = ALU_ADD; ID_RegDst = 1; ID_RegWrite = 1;
        for (int i = 0; i < 2; i++) begin
            tick();
            total++; if ({EX_A, EX_B, EX_StoreData} !== 96'h0) $display("FAIL reset_data A=%h B=%h SD=%h want 0", EX_A, EX_B, EX_StoreData); else passed++;
            total++; if ({EX_Valid, EX_RegWrite, EX_MemRead, EX_MemWrite, EX_MemToReg, LoadUseStall, EX_ALUControl, EX_WriteReg} !== 17'h0)
                $display("FAIL reset_ctrl got V=%b RW=%b MR=%b MW=%b M2R=%b LUS=%b ALU=%b WR=%0d want 0",
                         EX_Valid, EX_RegWrite, EX_MemRead, EX_MemWrite, EX_MemToReg, LoadUseStall, EX_ALUControl, EX_WriteReg);
            else passed++;
        end
        Rst = 0;
        tick();
        total++; if (EX_A !== 32'd5) $display("FAIL first_add EX_A got %h want 5", EX_A); else passed++;
        total++; if (EX_B !== 32'd3) $display("FAIL first_add EX_B got %h want 3", EX_B); else passed++;
        total++; if (EX_WriteReg !== 5'd3) $display("FAIL first_add EX_WriteReg got %0d want 3", EX_WriteReg); else passed++;
        total++; if (EX_Valid !== 1'b1 || EX_ALUControl !== ALU_ADD) $display("FAIL first_add V/ALU got %b/%b want 1/%b", EX_Valid, EX_ALUControl, ALU_ADD); else passed++;
    endtask

    task automatic test_mem_forward();
        logic [31:0] e;
        clear_id(); clear_fwd();
        ID_Valid = 1; ID_Rs = 4; ID_Rt = 6; ID_Rd = 7; ID_ReadData1 = 32'hAA; ID_ReadData2 = 32'hBB;
        ID_RegDst = 1; ID_RegWrite = 1; ID_ALUControl = ALU_ADD;
        tick();
        MEM_RegWrite = 1; MEM_WriteReg = 4; MEM_ALUResult = 32'h11;
        WB_RegWrite = 1; WB_WriteReg = 4; WB_WriteData = 32'h22;
        #1;
        e = FWD ? 32'h11 : 32'hAA;
        total++; if (EX_A !== e) $display("FAIL fwd_mem_prio EX_A got %h want %h", EX_A, e); else passed++;
        total++; if (EX_StoreData !== 32'hBB) $display("FAIL fwd_rt_nomatch StoreData got %h want bb", EX_StoreData); else passed++;
        MEM_RegWrite = 0;
        #1;
        e = FWD ? 32'h22 : 32'hAA;
        total++; if (EX_A !== e) $display("FAIL fwd_wb EX_A got %h want %h", EX_A, e); else passed++;
        ID_Rs = 0;
        tick();
        MEM_RegWrite = 1; MEM_WriteReg = 0; WB_WriteReg = 0;
        #1;
        total++; if (EX_A !== 32'hAA) $display("FAIL fwd_r0 EX_A got %h want aa", EX_A); else passed++;
        clear_fwd();
    endtask

    task automatic test_load_use();
        logic [31:0] e;
        clear_id(); clear_fwd();
        ID_Valid = 1; ID_Rs = 1; ID_Rt = 5; ID_ReadData1 = 32'h100; ID_SignExtImm = 8;
        ID_ALUSrc = 1; ID_RegWrite = 1; ID_MemRead = 1; ID_MemToReg = 1; ID_ALUControl = ALU_ADD;
        tick();
        clear_id();
        ID_Valid = 1; ID_Rs = 5; ID_Rt = 2; ID_Rd = 9; ID_ReadData1 = 0; ID_ReadData2 = 7;
        ID_RegDst = 1; ID_RegWrite = 1; ID_ALUControl = ALU_ADD;
        #1;
        total++; if (LoadUseStall !== FWD) $display("FAIL load_use_detect got %b want %b", LoadUseStall, FWD); else passed++;
        tick();
        total++; if (EX_Valid !== !FWD || EX_MemRead !== 1'b0) $display("FAIL load_use_bubble V/MR got %b/%b want %b/0", EX_Valid, EX_MemRead, !FWD); else passed++;
        total++; if (LoadUseStall !== 1'b0) $display("FAIL load_use_clear got %b want 0", LoadUseStall); else passed++;
        tick();
        MEM_RegWrite = 1; MEM_WriteReg = 5; MEM_ALUResult = 32'h1234;
        #1;
        e = FWD ? 32'h1234 : 32'h0;
        total++; if (EX_A !== e) $display("FAIL load_use_fwd EX_A got %h want %h", EX_A, e); else passed++;
        total++; if (EX_B !== 32'h7 || EX_Valid !== 1'b1 || EX_WriteReg !== 5'd9) $display("FAIL load_use_dep B/V/WR got %h/%b/%0d want 7/1/9", EX_B, EX_Valid, EX_WriteReg); else passed++;
        clear_fwd();
    endtask

    task automatic test_flush_stall();
        clear_id(); clear_fwd();
        ID_Valid = 1; ID_Rs = 1; ID_Rt = 2; ID_Rd = 3; ID_ReadData1 = 9; ID_RegWrite = 1;
        tick();
        Flush = 1; Stall = 1; ID_Rs = 3;
        tick();
        Flush = 0; Stall = 0;
        total++; if (EX_Valid !== 1'b0 || EX_A !== 32'h0 || EX_WriteReg !== 5'd0 || EX_RegWrite !== 1'b0)
            $display("FAIL flush_bubble V/A/WR/RW got %b/%h/%0d/%b want 0", EX_Valid, EX_A, EX_WriteReg, EX_RegWrite); else passed++;
        clear_id();
        ID_Valid = 1; ID_Rs = 7; ID_Rt = 8; ID_Rd = 12; ID_ReadData1 = 32'h55; ID_ReadData2 = 32'h66;
        ID_RegDst = 1; ID_RegWrite = 1; ID_ALUControl = ALU_SUB;
        tick();
        Stall = 1;
        for (int i = 0; i < 3; i++) begin
            ID_ReadData1 = $urandom; ID_ReadData2 = $urandom; ID_Rd = 5'(i + 20); ID_ALUControl = ALU_OR;
            tick();
            total++; if (EX_A !== 32'h55 || EX_B !== 32'h66 || EX_WriteReg !== 5'd12 || EX_ALUControl !== ALU_SUB || EX_Valid !== 1'b1)
                $display("FAIL stall_hold[%0d] A/B/WR/ALU/V got %h/%h/%0d/%b/%b want 55/66/12/%b/1", i, EX_A, EX_B, EX_WriteReg, EX_ALUControl, EX_Valid, ALU_SUB);
            else passed++;
        end
        Stall = 0;
    endtask

    task automatic test_shift_imm();
        logic [31:0] e;
        clear_id(); clear_fwd();
        ID_Valid = 1; ID_Rt = 8; ID_Rd = 10; ID_ReadData1 = 32'hDEAD; ID_ReadData2 = 32'h1; ID_Shamt = 2;
        ID_ShiftSrc = 1; ID_RegDst = 1; ID_RegWrite = 1; ID_ALUControl = ALU_SLL;
        tick();
        total++; if (EX_A !== 32'h1 || EX_B !== 32'h2) $display("FAIL sll_ops A/B got %h/%h want 1/2", EX_A, EX_B); else passed++;
        clear_id();
        ID_Valid = 1; ID_Rs = 3; ID_Rt = 11; ID_ReadData1 = 32'h10; ID_ReadData2 = 32'h99;
        ID_SignExtImm = 32'hFFFFFFFC; ID_ALUSrc = 1; ID_RegWrite = 1; ID_ALUControl = ALU_ADD;
        tick();
        total++; if (EX_B !== 32'hFFFFFFFC || EX_A !== 32'h10) $display("FAIL addi_ops A/B got %h/%h want 10/fffffffc", EX_A, EX_B); else passed++;
        total++; if (EX_WriteReg !== 5'd11) $display("FAIL addi_wr got %0d want 11", EX_WriteReg); else passed++;
        WB_RegWrite = 1; WB_WriteReg = 11; WB_WriteData = 32'h77;
        #1;
        e = FWD ? 32'h77 : 32'h99;
        total++; if (EX_StoreData !== e || EX_B !== 32'hFFFFFFFC) $display("FAIL addi_store SD/B got %h/%h want %h/fffffffc", EX_StoreData, EX_B, e); else passed++;
        clear_fwd();
    endtask

    task automatic test_random();
        for (int n = 0; n < 400; n++) begin
            Rst = ($urandom_range(0, 39) == 0); Flush = ($urandom_range(0, 7) == 0); Stall = ($urandom_range(0, 5) == 0);
            ID_Valid = 1'($urandom); ID_ReadData1 = $urandom; ID_ReadData2 = $urandom; ID_SignExtImm = $urandom;
            ID_Shamt = 5'($urandom); ID_Rs = 5'($urandom_range(0, 7)); ID_Rt = 5'($urandom_range(0, 7)); ID_Rd = 5'($urandom);
            ID_ALUControl = 6'($urandom); ID_ALUSrc = 1'($urandom); ID_ShiftSrc = ($urandom_range(0, 3) == 0);
            ID_RegDst = 1'($urandom); ID_RegWrite = 1'($urandom); ID_MemRead = ($urandom_range(0, 2) == 0);
            ID_MemWrite = 1'($urandom); ID_MemToReg = 1'($urandom);
            MEM_RegWrite = 1'($urandom); MEM_WriteReg = 5'($urandom_range(0, 7)); MEM_ALUResult = $urandom;
            WB_RegWrite = 1'($urandom); WB_WriteReg = 5'($urandom_range(0, 7)); WB_WriteData = $urandom;
            #1;
            total++; if (EX_A !== exp_a()) $display("FAIL rand_a[%0d] got %h want %h", n, EX_A, exp_a()); else passed++;
            total++; if (EX_B !== exp_b()) $display("FAIL rand_b[%0d] got %h want %h", n, EX_B, exp_b()); else passed++;
            total++; if (EX_StoreData !== fwd(m.rt, m.rd2)) $display("FAIL rand_sd[%0d] got %h want %h", n, EX_StoreData, fwd(m.rt, m.rd2)); else passed++;
            total++; if (LoadUseStall !== exp_hz()) $display("FAIL rand_lus[%0d] got %b want %b", n, LoadUseStall, exp_hz()); else passed++;
            total++; if ({EX_Valid, EX_RegWrite, EX_MemRead, EX_MemWrite, EX_MemToReg, EX_ALUControl, EX_WriteReg} !==
                         {m.valid, m.regwrite, m.memread, m.memwrite, m.memtoreg, m.aluc, m.wr})
                $display("FAIL rand_ctrl[%0d] got %b_%b_%b_%b_%b_%b_%0d want %b_%b_%b_%b_%b_%b_%0d", n,
                         EX_Valid, EX_RegWrite, EX_MemRead, EX_MemWrite, EX_MemToReg, EX_ALUControl, EX_WriteReg,
                         m.valid, m.regwrite, m.memread, m.memwrite, m.memtoreg, m.aluc, m.wr);
            else passed++;
            tick();
        end
        Rst = 0; Flush = 0; Stall = 0;
    endtask

    initial begin
        m = bubble();
        Rst = 1; Stall = 0; Flush = 0;
        clear_id(); clear_fwd();
        test_reset();
        test_mem_forward();
        test_load_use();
        test_flush_stall();
        test_shift_imm();
        test_random();
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
